battleship_gen2: RTL and testbench
==================================

BATTLESHIP_GEN2 -- requirements
Module: battleship_gen2

Interface
REQ-001 Parameter COORD_W, default 2: coordinate width; grid is G x G with G = 2^COORD_W (range 1..3).
REQ-002 Parameter SHIPS, default 4: ships per player; also the winning score (range 1..15).
REQ-003 Parameter SHOW_CYC, default 50: dwell cycles for SHOW_A, SHOW_B and SHOW_SCORE.
REQ-004 Parameter ERR_CYC, default 100: dwell cycles for ERR_A and ERR_B.
REQ-005 Parameter RES_CYC, default 100: dwell cycles for A_RES and B_RES.
REQ-006 clk  in  1  clock, all state changes on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  game start / restart request.
REQ-009 x, y  in  COORD_W each  target column / row.
REQ-010 pa_btn, pb_btn  in  1  player A / player B action buttons, synchronous level inputs.
REQ-011 disp3..disp0  out  8 each  7-segment patterns {dp,g..a}, active-high, disp3 leftmost.
REQ-012 led  out  8  status LEDs.

Function
REQ-013 start, pa_btn and pb_btn SHALL be rising-edge detected; each press acts exactly once, in the cycle after the edge is seen.
REQ-014 Cell index SHALL be y*G+x, taken from x and y in the press cycle; each map is a G*G-bit vector.
REQ-015 States: IDLE, SHOW_A, A_IN, ERR_A, SHOW_B, B_IN, ERR_B, SHOW_SCORE, A_SHOOT, A_RES, B_SHOOT, B_RES, A_WIN, B_WIN.
REQ-016 Dwell states SHALL last exactly their parameter in cycles (dwell counter clears on every state entry), then advance: SHOW_A->A_IN, SHOW_B->B_IN, SHOW_SCORE->A_SHOOT, ERR_A->A_IN, ERR_B->B_IN.
REQ-017 IDLE: start edge -> SHOW_A. Both maps, both counts and both scores SHALL be cleared.
REQ-018 A_IN: pa edge on an empty cell sets the mapA bit and increments cnt_a; on the SHIPS-th placement -> SHOW_B. On an occupied cell -> ERR_A with map and count unchanged.
REQ-019 B_IN mirrors REQ-018 with pb_btn, mapB and cnt_b; on completion -> SHOW_SCORE.
REQ-020 A_SHOOT: pa edge -> A_RES. A hit (mapB bit set) clears the bit, increments score_a and sets the hit flag; a miss (including a repeat shot) clears the hit flag.
REQ-021 A_RES: after RES_CYC, if score_a == SHIPS -> A_WIN, else -> B_SHOOT.
REQ-022 B_SHOOT and B_RES mirror REQ-020 and REQ-021 against mapA, with score_b; B_RES exits to B_WIN or A_SHOOT.
REQ-023 A_WIN and B_WIN SHALL hold until a start edge, then -> IDLE with all game state cleared.
REQ-024 Only the owning player's button acts in each state; the other button, and start outside IDLE/WIN, SHALL be ignored, including when pressed in the same cycle.
REQ-025 Counts and scores SHALL be 4 bits wide, saturate at SHIPS and never wrap.
REQ-026 Segment codes: digits 0-F hex; 'A' 0x77, 'b' 0x7C, 'E' 0x79, 'r' 0x50, 'o' 0x5C, 'I' 0x06, 'd' 0x5E, 'L' 0x38, 'H' 0x76, '-' 0x40; unlisted digit positions blank (0x00).
REQ-027 IDLE shows "IdLE" with led 0x99. SHOW_A / SHOW_B show 'A' / 'b' on disp3. ERR states show "Erro" with led 0x99.
REQ-028 In the IN and SHOOT states: disp3 = player letter, disp1 = x, disp0 = y. led = {A_side, B_side, 2'b00, cnt} in the IN states; led = {score_a, score_b} in the SHOOT states.
REQ-029 SHOW_SCORE and RES states: disp2 = score_a, disp1 = '-', disp0 = score_b, led = {score_a, score_b}. In RES states disp3 = 'H' on a hit, blank on a miss.
REQ-030 WIN states: disp3 = winner letter, scores as in REQ-029, led 0xFF.
REQ-031 All outputs SHALL be decoded from registered state only, with zero input-to-output combinational path except x/y display in the IN and SHOOT states.

Reset
REQ-032 While rst is high, the block SHALL be in IDLE with maps, counts, scores, dwell counter, hit flag and edge-detect history all zero; outputs show IDLE (REQ-027).
REQ-033 Reset asserted mid-game SHALL abandon the game immediately, and a button held through reset release SHALL NOT count as an edge.

Structure
REQ-034 Package battleship_pkg SHALL hold the state encoding and the segment constants of REQ-026.
REQ-035 The hex-digit decoder SHALL be the single sub-module seg7_hex (4-bit in, 8-bit out).

Verification
REQ-036 Default parameters: start, then 4 A placements at distinct cells -> SHOW_A lasts 50 cycles, led[3:0] counts 1..4, then SHOW_B.
REQ-037 A places at (1,2) twice -> ERR_A for exactly 100 cycles, cnt_a stays 1, then A_IN.
REQ-038 A shoots a B ship -> A_RES shows 'H', "1-0", led 0x10; a repeat shot at the same cell -> miss, score unchanged.
REQ-039 A sinks all 4 B ships -> A_WIN shows "A4-x" with led 0xFF; a start edge -> IDLE, all clear.
REQ-040 COORD_W=3, SHIPS=6: place at (7,7) and play a full game -> index 63 used, win at score 6.
REQ-041 pa_btn and pb_btn pressed together in A_IN -> only A acts; rst pulse mid-B_SHOOT -> IDLE, maps cleared.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared definitions for the two-player battleship game: state encoding and
// seven-segment glyph constants.
package battleship_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SHOW_A,
    S_A_IN,
    S_ERR_A,
    S_SHOW_B,
    S_B_IN,
    S_ERR_B,
    S_SHOW_SCORE,
    S_A_SHOOT,
    S_A_RES,
    S_B_SHOOT,
    S_B_RES,
    S_A_WIN,
    S_B_WIN
  } state_e;

  // Glyphs are {dp,g,f,e,d,c,b,a}, active-high.
  localparam logic [7:0] SEG_A     = 8'h77;
  localparam logic [7:0] SEG_B     = 8'h7C;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_R     = 8'h50;
  localparam logic [7:0] SEG_O     = 8'h5C;
  localparam logic [7:0] SEG_I     = 8'h06;
  localparam logic [7:0] SEG_D     = 8'h5E;
  localparam logic [7:0] SEG_L     = 8'h38;
  localparam logic [7:0] SEG_H     = 8'h76;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int DWELL_W = 16;

endpackage

// File: rtl/battleship_gen2_seg7_hex.sv
// Hex nibble to seven-segment pattern {dp,g..a}, active-high.
module seg7_hex (
  input  logic [3:0] val,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (val)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/battleship_gen2.sv
// Two-player battleship controller: placement, alternating shots, scoring,
// timed message screens and a four-digit seven-segment / LED status display.
module battleship_gen2
  import battleship_pkg::*;
#(
  parameter int COORD_W  = 2,
  parameter int SHIPS    = 4,
  parameter int SHOW_CYC = 50,
  parameter int ERR_CYC  = 100,
  parameter int RES_CYC  = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               pa_btn,
  input  logic               pb_btn,
  output logic [7:0]         disp3,
  output logic [7:0]         disp2,
  output logic [7:0]         disp1,
  output logic [7:0]         disp0,
  output logic [7:0]         led
);

  localparam int         CELLS   = 1 << (2 * COORD_W);
  localparam logic [3:0] SHIPS_L = 4'(SHIPS);

  state_e               state_q, state_d;
  logic [CELLS-1:0]     map_a_q, map_a_d, map_b_q, map_b_d;
  logic [3:0]           cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [3:0]           score_a_q, score_a_d, score_b_q, score_b_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d, dwell_lim;
  logic                 hit_q, hit_d;
  logic                 start_prev_q, pa_prev_q, pb_prev_q, armed_q;
  logic                 start_e, pa_e, pb_e, is_dwell, dwell_done;
  logic [2*COORD_W-1:0] idx;
  logic [3:0]           x_ext, y_ext;
  logic [7:0]           hex_x, hex_y, hex_sa, hex_sb;

  // armed_q stays low for the first clock after reset so a button held
  // through reset release never registers as a press.
  assign start_e = start  & ~start_prev_q & armed_q;
  assign pa_e    = pa_btn & ~pa_prev_q    & armed_q;
  assign pb_e    = pb_btn & ~pb_prev_q    & armed_q;
  assign idx     = {y, x};
  assign x_ext   = 4'(x);
  assign y_ext   = 4'(y);

  seg7_hex u_hex_x  (.val(x_ext),     .seg(hex_x));
  seg7_hex u_hex_y  (.val(y_ext),     .seg(hex_y));
  seg7_hex u_hex_sa (.val(score_a_q), .seg(hex_sa));
  seg7_hex u_hex_sb (.val(score_b_q), .seg(hex_sb));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      map_a_q      <= '0;
      map_b_q      <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      score_a_q    <= '0;
      score_b_q    <= '0;
      dwell_q      <= '0;
      hit_q        <= 1'b0;
      start_prev_q <= 1'b0;
      pa_prev_q    <= 1'b0;
      pb_prev_q    <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      map_a_q      <= map_a_d;
      map_b_q      <= map_b_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      dwell_q      <= dwell_d;
      hit_q        <= hit_d;
      start_prev_q <= start;
      pa_prev_q    <= pa_btn;
      pb_prev_q    <= pb_btn;
      armed_q      <= 1'b1;
    end
  end

  always_comb begin
    is_dwell  = 1'b1;
    dwell_lim = '0;
    case (state_q)
      S_SHOW_A, S_SHOW_B, S_SHOW_SCORE: dwell_lim = DWELL_W'(SHOW_CYC - 1);
      S_ERR_A, S_ERR_B:                 dwell_lim = DWELL_W'(ERR_CYC - 1);
      S_A_RES, S_B_RES:                 dwell_lim = DWELL_W'(RES_CYC - 1);
      default:                          is_dwell  = 1'b0;
    endcase
    dwell_done = is_dwell && (dwell_q == dwell_lim);
  end

  always_comb begin
    state_d   = state_q;
    map_a_d   = map_a_q;
    map_b_d   = map_b_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    hit_d     = hit_q;
    case (state_q)
      S_IDLE, S_A_WIN, S_B_WIN: begin
        if (start_e) begin
          state_d   = (state_q == S_IDLE) ? S_SHOW_A : S_IDLE;
          map_a_d   = '0;
          map_b_d   = '0;
          cnt_a_d   = '0;
          cnt_b_d   = '0;
          score_a_d = '0;
          score_b_d = '0;
          hit_d     = 1'b0;
        end
      end
      S_SHOW_A:     if (dwell_done) state_d = S_A_IN;
      S_ERR_A:      if (dwell_done) state_d = S_A_IN;
      S_SHOW_B:     if (dwell_done) state_d = S_B_IN;
      S_ERR_B:      if (dwell_done) state_d = S_B_IN;
      S_SHOW_SCORE: if (dwell_done) state_d = S_A_SHOOT;
      S_A_IN: begin
        if (pa_e) begin
          if (map_a_q[idx]) state_d = S_ERR_A;
          else begin
            map_a_d[idx] = 1'b1;
            if (cnt_a_q < SHIPS_L) cnt_a_d = cnt_a_q + 4'd1;
            if (cnt_a_q >= SHIPS_L - 4'd1) state_d = S_SHOW_B;
          end
        end
      end
      S_B_IN: begin
        if (pb_e) begin
          if (map_b_q[idx]) state_d = S_ERR_B;
          else begin
            map_b_d[idx] = 1'b1;
            if (cnt_b_q < SHIPS_L) cnt_b_d = cnt_b_q + 4'd1;
            if (cnt_b_q >= SHIPS_L - 4'd1) state_d = S_SHOW_SCORE;
          end
        end
      end
      S_A_SHOOT: begin
        if (pa_e) begin
          state_d = S_A_RES;
          hit_d   = map_b_q[idx];
          if (map_b_q[idx]) begin
            map_b_d[idx] = 1'b0;
            if (score_a_q < SHIPS_L) score_a_d = score_a_q + 4'd1;
          end
        end
      end
      S_B_SHOOT: begin
        if (pb_e) begin
          state_d = S_B_RES;
          hit_d   = map_a_q[idx];
          if (map_a_q[idx]) begin
            map_a_d[idx] = 1'b0;
            if (score_b_q < SHIPS_L) score_b_d = score_b_q + 4'd1;
          end
        end
      end
      S_A_RES: if (dwell_done) state_d = (score_a_q == SHIPS_L) ? S_A_WIN : S_B_SHOOT;
      S_B_RES: if (dwell_done) state_d = (score_b_q == SHIPS_L) ? S_B_WIN : S_A_SHOOT;
      default: state_d = S_IDLE;
    endcase
    dwell_d = (is_dwell && state_d == state_q) ? dwell_q + 1'b1 : '0;
  end

  always_comb begin
    disp3 = SEG_BLANK;
    disp2 = SEG_BLANK;
    disp1 = SEG_BLANK;
    disp0 = SEG_BLANK;
    led   = 8'h00;
    case (state_q)
      S_IDLE: begin
        {disp3, disp2, disp1, disp0} = {SEG_I, SEG_D, SEG_L, SEG_E};
        led = 8'h99;
      end
      S_ERR_A, S_ERR_B: begin
        {disp3, disp2, disp1, disp0} = {SEG_E, SEG_R, SEG_R, SEG_O};
        led = 8'h99;
      end
      S_SHOW_A: disp3 = SEG_A;
      S_SHOW_B: disp3 = SEG_B;
      S_A_IN, S_B_IN, S_A_SHOOT, S_B_SHOOT: begin
        disp3 = (state_q == S_A_IN || state_q == S_A_SHOOT) ? SEG_A : SEG_B;
        disp1 = hex_x;
        disp0 = hex_y;
        case (state_q)
          S_A_IN:  led = {4'b1000, cnt_a_q};
          S_B_IN:  led = {4'b0100, cnt_b_q};
          default: led = {score_a_q, score_b_q};
        endcase
      end
      S_SHOW_SCORE, S_A_RES, S_B_RES, S_A_WIN, S_B_WIN: begin
        disp2 = hex_sa;
        disp1 = SEG_DASH;
        disp0 = hex_sb;
        led   = {score_a_q, score_b_q};
        if (state_q == S_A_WIN || state_q == S_B_WIN) begin
          disp3 = (state_q == S_A_WIN) ? SEG_A : SEG_B;
          led   = 8'hFF;
        end else if (state_q != S_SHOW_SCORE && hit_q) begin
          disp3 = SEG_H;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_battleship_gen2.sv
// Randomized self-checking bench: a game-level model predicts every display
// and LED value for a default instance and a COORD_W=3 / SHIPS=6 instance.
module tb_battleship_gen2;

  localparam int PH_IDLE = 0, PH_SHOWA = 1, PH_SHOWB = 2, PH_ERR = 3, PH_AIN = 4,
                 PH_BIN = 5, PH_ASHOOT = 6, PH_BSHOOT = 7, PH_SCORE = 8, PH_RES = 9,
                 PH_AWIN = 10, PH_BWIN = 11;
  localparam logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, pa_i, pb_i;
  logic [2:0] x_i, y_i;
  int         sel;
  logic [7:0] d0_3, d0_2, d0_1, d0_0, led0;
  logic [7:0] d1_3, d1_2, d1_1, d1_0, led1;
  logic       st0, pa0, pb0, st1, pa1, pb1;

  int G, S, cnt_a, cnt_b, sc_a, sc_b;
  bit mapa [64];
  bit mapb [64];
  bit hit;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  assign st0 = (sel == 0) & start_i;
  assign pa0 = (sel == 0) & pa_i;
  assign pb0 = (sel == 0) & pb_i;
  assign st1 = (sel == 1) & start_i;
  assign pa1 = (sel == 1) & pa_i;
  assign pb1 = (sel == 1) & pb_i;

  battleship_gen2 dut0 (
    .clk(clk), .rst(rst), .start(st0), .x(x_i[1:0]), .y(y_i[1:0]),
    .pa_btn(pa0), .pb_btn(pb0),
    .disp3(d0_3), .disp2(d0_2), .disp1(d0_1), .disp0(d0_0), .led(led0));

  battleship_gen2 #(.COORD_W(3), .SHIPS(6)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .x(x_i), .y(y_i),
    .pa_btn(pa1), .pb_btn(pb1),
    .disp3(d1_3), .disp2(d1_2), .disp1(d1_1), .disp0(d1_0), .led(led1));

  function automatic logic [39:0] view();
    return (sel == 1) ? {d1_3, d1_2, d1_1, d1_0, led1} : {d0_3, d0_2, d0_1, d0_0, led0};
  endfunction

  function automatic logic [39:0] expv(int ph);
    logic [7:0] hx, hy, sa, sb, ss;
    hx = HEX[{1'b0, x_i}];
    hy = HEX[{1'b0, y_i}];
    sa = HEX[sc_a[3:0]];
    sb = HEX[sc_b[3:0]];
    ss = {sc_a[3:0], sc_b[3:0]};
    case (ph)
      PH_IDLE:   return {8'h06, 8'h5E, 8'h38, 8'h79, 8'h99};
      PH_SHOWA:  return {8'h77, 32'h0};
      PH_SHOWB:  return {8'h7C, 32'h0};
      PH_ERR:    return {8'h79, 8'h50, 8'h50, 8'h5C, 8'h99};
      PH_AIN:    return {8'h77, 8'h00, hx, hy, 4'b1000, cnt_a[3:0]};
      PH_BIN:    return {8'h7C, 8'h00, hx, hy, 4'b0100, cnt_b[3:0]};
      PH_ASHOOT: return {8'h77, 8'h00, hx, hy, ss};
      PH_BSHOOT: return {8'h7C, 8'h00, hx, hy, ss};
      PH_SCORE:  return {8'h00, sa, 8'h40, sb, ss};
      PH_RES:    return {(hit ? 8'h76 : 8'h00), sa, 8'h40, sb, ss};
      PH_AWIN:   return {8'h77, sa, 8'h40, sb, 8'hFF};
      PH_BWIN:   return {8'h7C, sa, 8'h40, sb, 8'hFF};
      default:   return 40'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 start, 1 pa, 2 pb, 3 pa+pb together
  task automatic press(int which);
    tick();
    start_i = (which == 0);
    pa_i    = (which == 1) || (which == 3);
    pb_i    = (which == 2) || (which == 3);
    tick();
    start_i = 1'b0;
    pa_i    = 1'b0;
    pb_i    = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      mapa[i] = 1'b0;
      mapb[i] = 1'b0;
    end
    cnt_a = 0; cnt_b = 0; sc_a = 0; sc_b = 0; hit = 1'b0;
  endtask

  task automatic set_sel(int s);
    sel = s;
    G   = (s == 1) ? 8 : 4;
    S   = (s == 1) ? 6 : 4;
  endtask

  task automatic measure(int ph, output int n);
    n = 0;
    while (view() === expv(ph) && n < 400) begin
      n++;
      tick();
    end
  endtask

  // Random cell of mapa (which=0) or mapb (which=1) whose bit equals want.
  task automatic pick(int which, bit want, output int xx, output int yy);
    int c;
    c = 0;
    for (int k = 0; k < 2000; k++) begin
      c = $urandom_range(0, G * G - 1);
      if (((which == 0) ? mapa[c] : mapb[c]) == want) break;
    end
    xx = c % G;
    yy = c / G;
  endtask

  task automatic start_game();
    int n;
    press(0);
    clear_model();
    measure(PH_SHOWA, n);
    total++;
    if (n !== 50) begin bad++; $display("FAIL show_a_dwell got=%0d exp=50", n); end
  endtask

  task automatic do_place(int p, int xx, int yy);
    int n, c;
    logic [39:0] e;
    x_i = 3'(xx); y_i = 3'(yy);
    c = yy * G + xx;
    press(p == 0 ? 1 : 2);
    if ((p == 0 && mapa[c]) || (p == 1 && mapb[c])) begin
      measure(PH_ERR, n);
      total++;
      if (n !== 100) begin bad++; $display("FAIL err_dwell got=%0d exp=100", n); end
      e = expv(p == 0 ? PH_AIN : PH_BIN);
      total++;
      if (view() !== e) begin bad++; $display("FAIL err_return got=%h exp=%h", view(), e); end
    end else begin
      if (p == 0) begin mapa[c] = 1'b1; cnt_a++; end
      else        begin mapb[c] = 1'b1; cnt_b++; end
      if ((p == 0 ? cnt_a : cnt_b) == S) begin
        measure(p == 0 ? PH_SHOWB : PH_SCORE, n);
        total++;
        if (n !== 50) begin bad++; $display("FAIL place_done_dwell got=%0d exp=50", n); end
      end else begin
        e = expv(p == 0 ? PH_AIN : PH_BIN);
        total++;
        if (view() !== e) begin bad++; $display("FAIL place got=%h exp=%h", view(), e); end
      end
    end
  endtask

  task automatic do_shoot(int p, int xx, int yy);
    int n, c, nx;
    logic [39:0] e;
    x_i = 3'(xx); y_i = 3'(yy);
    c = yy * G + xx;
    press(p == 0 ? 1 : 2);
    if (p == 0) begin
      hit = mapb[c];
      if (hit) begin mapb[c] = 1'b0; if (sc_a < S) sc_a++; end
    end else begin
      hit = mapa[c];
      if (hit) begin mapa[c] = 1'b0; if (sc_b < S) sc_b++; end
    end
    e = expv(PH_RES);
    total++;
    if (view() !== e) begin bad++; $display("FAIL res_view got=%h exp=%h", view(), e); end
    measure(PH_RES, n);
    total++;
    if (n !== 100) begin bad++; $display("FAIL res_dwell got=%0d exp=100", n); end
    if (p == 0) nx = (sc_a == S) ? PH_AWIN : PH_BSHOOT;
    else        nx = (sc_b == S) ? PH_BWIN : PH_ASHOOT;
    e = expv(nx);
    total++;
    if (view() !== e) begin bad++; $display("FAIL after_res got=%h exp=%h", view(), e); end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    start_i = 1'b0; pa_i = 1'b0; pb_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_model();
  endtask

  task automatic place_all(int p, bit corner);
    int xx, yy;
    if (corner) do_place(p, G - 1, G - 1);
    for (int k = 0; k < 40 && (p == 0 ? cnt_a : cnt_b) < S; k++) begin
      xx = $urandom_range(0, G - 1);
      yy = $urandom_range(0, G - 1);
      do_place(p, xx, yy);
    end
  endtask

  // A aims at B ships, B always misses, until A wins.
  task automatic play_a_wins(bit corner_first);
    int xx, yy;
    for (int k = 0; k < 20 && sc_a < S; k++) begin
      if (k == 0 && corner_first) begin xx = G - 1; yy = G - 1; end
      else pick(1, 1'b1, xx, yy);
      do_shoot(0, xx, yy);
      if (sc_a < S) begin
        pick(0, 1'b0, xx, yy);
        do_shoot(1, xx, yy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b1; pa_i = 1'b1; pb_i = 1'b0;
    x_i = 3'd0; y_i = 3'd0;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      set_sel(s);
      total++;
      if (view() !== expv(PH_IDLE)) begin bad++; $display("FAIL reset_idle got=%h exp=%h", view(), expv(PH_IDLE)); end
    end
    set_sel(0);
    rst = 1'b0;
    tick(); tick(); tick();
    total++;
    if (view() !== expv(PH_IDLE)) begin bad++; $display("FAIL held_start got=%h exp=%h", view(), expv(PH_IDLE)); end
    start_i = 1'b0; pa_i = 1'b0;
    clear_model();
  endtask

  task automatic test_place_a();
    int xx, yy;
    logic [39:0] e;
    start_game();
    e = expv(PH_AIN);
    total++;
    if (view() !== e) begin bad++; $display("FAIL a_in_entry got=%h exp=%h", view(), e); end
    do_place(0, 1, 2);
    do_place(0, 1, 2);
    pick(0, 1'b0, xx, yy);
    x_i = 3'(xx); y_i = 3'(yy);
    press(3);
    mapa[yy * G + xx] = 1'b1; cnt_a++;
    e = expv(PH_AIN);
    total++;
    if (view() !== e) begin bad++; $display("FAIL both_btn got=%h exp=%h", view(), e); end
    press(0);
    press(2);
    total++;
    if (view() !== e) begin bad++; $display("FAIL others_ignored got=%h exp=%h", view(), e); end
    place_all(0, 1'b0);
  endtask

  task automatic test_place_b();
    logic [39:0] e;
    press(1);
    e = expv(PH_BIN);
    total++;
    if (view() !== e) begin bad++; $display("FAIL pa_in_b_in got=%h exp=%h", view(), e); end
    place_all(1, 1'b0);
    e = expv(PH_ASHOOT);
    total++;
    if (view() !== e) begin bad++; $display("FAIL shoot_entry got=%h exp=%h", view(), e); end
  endtask

  task automatic test_shoot();
    int xx, yy, mx, my, n;
    logic [39:0] e;
    pick(1, 1'b1, xx, yy);
    x_i = 3'(xx); y_i = 3'(yy);
    press(1);
    mapb[yy * G + xx] = 1'b0; sc_a = 1; hit = 1'b1;
    total++;
    if (view() !== 40'h76_06_40_3F_10) begin bad++; $display("FAIL first_hit got=%h exp=7606403f10", view()); end
    measure(PH_RES, n);
    total++;
    if (n !== 100) begin bad++; $display("FAIL first_res_dwell got=%0d exp=100", n); end
    pick(0, 1'b0, mx, my);
    do_shoot(1, mx, my);
    do_shoot(0, xx, yy);
    total++;
    if (sc_a !== 1 || hit !== 1'b0) begin bad++; $display("FAIL repeat_model got=%0d exp=1", sc_a); end
    pick(0, 1'b0, mx, my);
    do_shoot(1, mx, my);
    play_a_wins(1'b0);
    e = {8'h77, HEX[4], 8'h40, HEX[sc_b[3:0]], 8'hFF};
    total++;
    if (view() !== e) begin bad++; $display("FAIL a_win got=%h exp=%h", view(), e); end
    press(0);
    clear_model();
    total++;
    if (view() !== expv(PH_IDLE)) begin bad++; $display("FAIL win_to_idle got=%h exp=%h", view(), expv(PH_IDLE)); end
    start_game();
    do_place(0, 1, 2);
  endtask

  task automatic test_reset_mid();
    int xx, yy;
    place_all(0, 1'b0);
    place_all(1, 1'b0);
    pick(1, 1'b0, xx, yy);
    do_shoot(0, xx, yy);
    x_i = 3'd1; y_i = 3'd2;
    pb_i = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    clear_model();
    total++;
    if (view() !== expv(PH_IDLE)) begin bad++; $display("FAIL rst_mid got=%h exp=%h", view(), expv(PH_IDLE)); end
    tick();
    rst = 1'b0;
    tick(); tick();
    pb_i = 1'b0;
    total++;
    if (view() !== expv(PH_IDLE)) begin bad++; $display("FAIL rst_mid_hold got=%h exp=%h", view(), expv(PH_IDLE)); end
    start_game();
    do_place(0, 1, 2);
  endtask

  task automatic test_big();
    logic [39:0] e;
    reset_all();
    set_sel(1);
    start_game();
    place_all(0, 1'b1);
    place_all(1, 1'b1);
    play_a_wins(1'b1);
    e = {8'h77, HEX[6], 8'h40, HEX[sc_b[3:0]], 8'hFF};
    total++;
    if (view() !== e) begin bad++; $display("FAIL big_win got=%h exp=%h", view(), e); end
  endtask

  initial begin
    set_sel(0);
    rst = 1'b1;
    start_i = 1'b0; pa_i = 1'b0; pb_i = 1'b0;
    x_i = 3'd0; y_i = 3'd0;
    test_reset();
    test_place_a();
    test_place_b();
    test_shoot();
    test_reset_mid();
    test_big();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
